// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor: the carry chain is split into STAGES chunks, one per stage,
// with a valid/ready handshake, optional signed saturation and registered status flags.
module pipelined_add_sub #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned SAT    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int unsigned W = N / STAGES;

    logic              adv;
    logic [N-1:0]      st_a [STAGES];
    logic [N-1:0]      st_b [STAGES];
    logic [N-1:0]      st_r [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    // The whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign st_a[0] = a;
    assign st_b[0] = sub ? ~b : b;
    assign st_r[0] = '0;
    assign st_c[0] = sub ? ~cin : cin;
    assign st_v[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W:0]   chunk;
        logic [N-1:0] raw;

        assign chunk = {1'b0, st_a[k][k*W +: W]} + {1'b0, st_b[k][k*W +: W]}
                     + {{W{1'b0}}, st_c[k]};

        always_comb begin
            raw              = st_r[k];
            raw[k*W +: W]    = chunk[W-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic [N-1:0] a_q, b_q, r_q;
            logic         c_q, v_q;

            // Operands travel with the beat so higher chunks meet their carry one stage later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                    r_q <= raw;
                    c_q <= chunk[W];
                    v_q <= st_v[k];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_r[k+1] = r_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
        end else begin : g_last
            logic         ovf_c;
            logic [N-1:0] sum_c;

            assign ovf_c = (st_a[k][N-1] == st_b[k][N-1]) && (raw[N-1] != st_a[k][N-1]);

            always_comb begin
                sum_c = raw;
                if (SAT != 0 && ovf_c) begin
                    sum_c = st_a[k][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                    neg       <= 1'b0;
                end else if (adv) begin
                    out_valid <= st_v[k];
                    sum       <= sum_c;
                    cout      <= chunk[W];
                    ovf       <= ovf_c;
                    zero      <= (sum_c == '0);
                    neg       <= sum_c[N-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations share one stimulus stream and each is
// checked every cycle against an arithmetic model through its own expected-result queue.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a, b;
    logic        cin, sub, out_ready;
    logic [2:0]  v;

    logic       r0_inr, r0_ov, r0_co, r0_of, r0_z, r0_n;
    logic [7:0] r0_sum;
    logic       r1_inr, r1_ov, r1_co, r1_of, r1_z, r1_n;
    logic [7:0] r1_sum;
    logic        r2_inr, r2_ov, r2_co, r2_of, r2_z, r2_n;
    logic [31:0] r2_sum;

    res_t       exp_q [3][$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] acc;
    logic [2:0] stall_prev;
    int         stall_cnt;
    bit         stall_done;
    int         n_of   [3] = '{8, 8, 32};
    int         sat_of [3] = '{0, 1, 0};
    int         stg_of [3] = '{2, 2, 4};

    logic [31:0] tbl_a   [6] = '{32'h7F, 32'hFF, 32'h05, 32'h05, 32'h80, 32'h00};
    logic [31:0] tbl_b   [6] = '{32'h01, 32'h01, 32'h07, 32'h03, 32'h01, 32'h80};
    logic        tbl_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        tbl_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    pipelined_add_sub #(.N(8), .STAGES(2), .SAT(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(r0_inr), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(r0_ov), .out_ready(out_ready), .sum(r0_sum),
        .cout(r0_co), .ovf(r0_of), .zero(r0_z), .neg(r0_n)
    );

    pipelined_add_sub #(.N(8), .STAGES(2), .SAT(1)) u_dut8s (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(r1_inr), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .sub(sub), .out_valid(r1_ov), .out_ready(out_ready), .sum(r1_sum),
        .cout(r1_co), .ovf(r1_of), .zero(r1_z), .neg(r1_n)
    );

    pipelined_add_sub #(.N(32), .STAGES(4), .SAT(0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_ready(r2_inr), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(r2_ov), .out_ready(out_ready), .sum(r2_sum),
        .cout(r2_co), .ovf(r2_of), .zero(r2_z), .neg(r2_n)
    );

    // Signed/unsigned integer arithmetic on wide integers, independent of any carry chain.
    function automatic res_t model(input int n, input int sat, input logic [31:0] x,
                                   input logic [31:0] y, input logic ci, input logic sb);
        longint m, ux, uy, sx, sy, sres, full, maxs, mins;
        res_t   r;
        m    = longint'(1) << n;
        ux   = longint'(x) & (m - 1);
        uy   = longint'(y) & (m - 1);
        sx   = (ux >= m / 2) ? ux - m : ux;
        sy   = (uy >= m / 2) ? uy - m : uy;
        maxs = m / 2 - 1;
        mins = -(m / 2);
        if (!sb) begin
            full   = ux + uy + longint'(ci);
            r.cout = (full >= m);
            sres   = sx + sy + longint'(ci);
        end else begin
            full   = ux - uy - longint'(ci);
            r.cout = (full >= 0);
            sres   = sx - sy - longint'(ci);
        end
        r.ovf = (sres > maxs) || (sres < mins);
        if (sat != 0 && r.ovf) full = (sres > maxs) ? maxs : mins;
        r.sum  = 32'(full & (m - 1));
        r.zero = (r.sum == 32'h0);
        r.neg  = r.sum[n-1];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic sample_port(input int k, input logic inv, input logic inr, input logic ov,
                               input logic ordy, input logic [31:0] s, input logic co,
                               input logic of, input logic z, input logic ng);
        res_t got;
        got = '{sum: s, cout: co, ovf: of, zero: z, neg: ng};
        chk($sformatf("in_ready[%0d]", k), 64'(inr), 64'(!ov || ordy));
        if (stall_prev[k]) chk($sformatf("stall_hold_valid[%0d]", k), 64'(ov), 64'(1));
        if (ov) begin
            if (exp_q[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_result[%0d] got %0h want none at %0t", k, s, $time);
            end else begin
                chk($sformatf("result[%0d]", k), 64'(got), 64'(exp_q[k][0]));
                if (ordy) void'(exp_q[k].pop_front());
            end
        end
        acc[k] = inv && inr;
        if (acc[k]) begin
            exp_q[k].push_back(model(n_of[k], sat_of[k], a, b, cin, sub));
            chk($sformatf("in_flight[%0d]", k), 64'(exp_q[k].size() <= stg_of[k]), 64'(1));
        end
        stall_prev[k] = ov && !ordy;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            sample_port(0, v[0], r0_inr, r0_ov, out_ready, {24'h0, r0_sum}, r0_co, r0_of,
                        r0_z, r0_n);
            sample_port(1, v[1], r1_inr, r1_ov, out_ready, {24'h0, r1_sum}, r1_co, r1_of,
                        r1_z, r1_n);
            sample_port(2, v[2], r2_inr, r2_ov, out_ready, r2_sum, r2_co, r2_of, r2_z, r2_n);
        end
    end

    task automatic stall_step(input int mode);
        if (mode == 1) begin
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) out_ready = 1'b1;
            end else if (!stall_done && r0_ov && out_ready) begin
                out_ready  = 1'b0;
                stall_cnt  = 3;
                stall_done = 1'b1;
            end
        end else if (mode == 2) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain(input int stall);
        int guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            stall_step(stall);
            guard++;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
    endtask

    // Each beat is held per instance until that instance has taken it.
    task automatic run(input int nbeats, input int random_ops, input int stall);
        int guard;
        stall_cnt  = 0;
        stall_done = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (random_ops == 0) begin
                a = tbl_a[i]; b = tbl_b[i]; cin = tbl_cin[i]; sub = tbl_sub[i];
            end else begin
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            v     = 3'b111;
            guard = 0;
            while (v != 3'b000 && guard < 50) begin
                @(posedge clk);
                #1;
                v = v & ~acc;
                stall_step(stall);
                guard++;
            end
            chk("accept_in_time", 64'(v), 64'(0));
            v = 3'b000;
        end
        drain(stall);
    endtask

    task automatic lat_check(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                             input logic ts, input logic [7:0] e0, input logic [7:0] e1);
        int c0 = -1;
        int c2 = -1;
        @(posedge clk);
        #1;
        a = ta; b = tb_v; cin = tc; sub = ts; v = 3'b111;
        @(posedge clk);
        #1;
        v = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (c0 < 0 && r0_ov) begin
                c0 = i;
                chk("literal_sum8", 64'(r0_sum), 64'(e0));
                chk("literal_sum8_sat", 64'(r1_sum), 64'(e1));
            end
            if (c2 < 0 && r2_ov) c2 = i;
        end
        chk("latency_s2", 64'(c0), 64'(1));
        chk("latency_s4", 64'(c2), 64'(3));
    endtask

    task automatic outputs_zero();
        chk("reset_out8", 64'({r0_ov, r0_sum, r0_co, r0_of, r0_z, r0_n}), 64'(0));
        chk("reset_out8s", 64'({r1_ov, r1_sum, r1_co, r1_of, r1_z, r1_n}), 64'(0));
        chk("reset_out32", 64'({r2_ov, r2_sum, r2_co, r2_of, r2_z, r2_n}), 64'(0));
    endtask

    task automatic ready_after_reset();
        chk("ready_after_reset", 64'({r0_inr, r1_inr, r2_inr}), 64'(3'b111));
    endtask

    initial begin
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; v = 3'b000; out_ready = 1'b1;
        acc = '0; stall_prev = '0; stall_cnt = 0; stall_done = 1'b0;

        // Hand-computed pins on the model itself.
        chk("pin_add_ovf", 64'(model(8, 0, 32'h7F, 32'h01, 1'b0, 1'b0)),
            64'(res_t'{sum: 32'h80, cout: 1'b0, ovf: 1'b1, zero: 1'b0, neg: 1'b1}));
        chk("pin_wrap_zero", 64'(model(8, 0, 32'hFF, 32'h01, 1'b0, 1'b0)),
            64'(res_t'{sum: 32'h00, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0}));
        chk("pin_sub_borrow", 64'(model(8, 0, 32'h05, 32'h07, 1'b0, 1'b1)),
            64'(res_t'{sum: 32'hFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1}));
        chk("pin_sub_cin", 64'(model(8, 0, 32'h05, 32'h03, 1'b1, 1'b1)),
            64'(res_t'{sum: 32'h01, cout: 1'b1, ovf: 1'b0, zero: 1'b0, neg: 1'b0}));
        chk("pin_sat_pos", 64'(model(8, 1, 32'h7F, 32'h01, 1'b0, 1'b0)),
            64'(res_t'{sum: 32'h7F, cout: 1'b0, ovf: 1'b1, zero: 1'b0, neg: 1'b0}));
        chk("pin_sat_neg", 64'(model(8, 1, 32'h80, 32'h01, 1'b0, 1'b1)),
            64'(res_t'{sum: 32'h80, cout: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b1}));

        #2;
        outputs_zero();
        #10;
        rst_n = 1'b1;
        #1;
        ready_after_reset();

        lat_check(32'h7F, 32'h01, 1'b0, 1'b0, 8'h80, 8'h7F);
        run(6, 0, 0);
        run(4, 0, 1);
        run(4, 1, 1);
        run(40, 1, 2);

        // Two beats in flight, then reset between clock edges.
        @(posedge clk);
        #1;
        a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0; v = 3'b111;
        @(posedge clk);
        #1;
        a = 32'h33; b = 32'h01; sub = 1'b1;
        @(posedge clk);
        #1;
        v = 3'b000;
        #1;
        rst_n = 1'b0;
        #1;
        outputs_zero();
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        stall_prev = '0;
        acc        = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        ready_after_reset();

        lat_check(32'h05, 32'h03, 1'b1, 1'b1, 8'h01, 8'h01);
        run(8, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined N-bit adder/subtractor with a valid/ready streaming handshake, a configurable number of carry-chain pipeline stages, optional signed saturation and registered status flags. It replaces the single-cycle combinational ripple adder wherever wide operands or a high clock rate make a full carry chain per cycle infeasible. Typical users are datapath accumulators and address generators.

## Interface
- N, default 32: operand and result width in bits; must be a multiple of STAGES.
- STAGES, default 4: number of pipeline stages; each stage resolves one W = N/STAGES bit chunk of the carry chain; 1 ≤ STAGES ≤ N.
- SAT, default 0: 1 enables signed saturation of the result on overflow.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in when adding; borrow-in when subtracting.
- sub  in  1  0 selects a+b+cin; 1 selects a−b−cin.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result.
- cout  out  1  raw carry out of the MSB (for subtraction: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow of the unsaturated result.
- zero  out  1  sum == 0 (after saturation).
- neg  out  1  sum[N-1] (after saturation).

## Operation
- Effective operand: b_eff = sub ? ~b : b; effective carry c0 = sub ? ~cin : cin. Raw result = a + b_eff + c0, taken modulo 2^N; cout is bit N.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff with the carry registered from stage k−1 (stage 0 uses c0). It registers the W-bit chunk and its carry out.
- Skew registers delay the higher operand chunks so that chunk k enters stage k. Deskew registers delay the lower result chunks so that all chunks of one beat leave together.
- The final stage also registers the following:
  - ovf = (a[N-1] == b_eff[N-1]) && (raw[N-1] != a[N-1]).
  - SAT=1 and ovf=1: sum = a[N-1] ? {1'b1, {N-1{1'b0}}} : {1'b0, {N-1{1'b1}}}. Otherwise sum = raw.
  - zero and neg are derived from the final sum. cout is always the raw carry, unaffected by saturation.
- Each stage carries a valid bit. Global advance: adv = !out_valid || out_ready. in_ready = adv. This is a combinational path from out_ready.
- When adv=1, every stage shifts one position, and stage 0 loads the input beat (valid = in_valid). When adv=0, all stages hold, and sum and flags remain stable while out_valid=1.
- A transfer occurs on a cycle where valid && ready. Beats are never dropped, duplicated or reordered.
- Reset (rst_n low, asynchronous): all valid bits, out_valid, sum, cout, ovf, zero and neg go to 0. In-flight beats are discarded. in_ready = 1 as soon as reset is released.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1, i.e. STAGES cycles of register delay with no stall.
- Throughput: one beat per cycle while out_ready=1.
- Bubbles propagate: in_valid=0 with adv=1 inserts an invalid slot.
- Stall: if out_valid=1 and out_ready=0, in_ready=0 in that same cycle and the pipeline freezes. Stalling releases on the first cycle with out_ready=1.
- Empty pipeline plus continuous in_valid reaches full throughput; at most STAGES beats are in flight.
- STAGES=1: the result is registered once, latency 1.
- Reset assertion takes effect without a clock edge. Release is synchronous to the first clk edge after rst_n rises.
- Critical path: a W-bit ripple in any stage, plus the flag and saturation logic in the final stage.

## Test plan
All scenarios use N=8, STAGES=2 unless stated.
- Add overflow, SAT=0: a=0x7F, b=0x01, cin=0, sub=0 → 2 cycles later sum=0x80, cout=0, ovf=1, neg=1, zero=0.
- Wrap to zero: a=0xFF, b=0x01, cin=0, sub=0 → sum=0x00, cout=1, ovf=0, zero=1, neg=0.
- Subtract with borrow: a=0x05, b=0x07, cin=0, sub=1 → sum=0xFE, cout=0, ovf=0, neg=1. Then a=0x05, b=0x03, cin=1, sub=1 → sum=0x01, cout=1.
- Saturation, SAT=1: a=0x7F + b=0x01 → sum=0x7F, ovf=1. Then a=0x80 − b=0x01 (sub=1) → sum=0x80, ovf=1, neg=1.
- Backpressure: stream 4 beats back-to-back, with out_ready low for 3 cycles once the first result is valid. Required response:
  - in_ready drops in the same cycle.
  - sum and flags hold constant.
  - All 4 results emerge in order with none lost or duplicated.
  - Repeat with STAGES=4 and N=32 on random operands against a golden model.
- Reset mid-stream: 2 beats in flight, pull rst_n low between edges. Required response:
  - out_valid and all outputs go to 0 immediately.
  - After release, in_ready=1 and no stale results appear.
  - The next accepted beat returns correctly after STAGES cycles.
